// File: rtl/count_sequencer.sv
// Run-control FSM and tick prescaler for an N-bit up-counter.
// Start/pause/resume/stop with free-run (wrap at limit) or one-shot (halt at limit) counting.
module count_sequencer #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 4
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_start,
    input  logic             i_pause,
    input  logic             i_stop,
    input  logic             i_mode,
    input  logic [WIDTH-1:0] i_limit,
    output logic [WIDTH-1:0] o_count,
    output logic             o_busy,
    output logic             o_tick,
    output logic             o_wrap,
    output logic             o_done,
    output logic [1:0]       o_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    // A one-cycle prescaler still needs a 1-bit divider that simply stays at zero.
    localparam int            DW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(PRESCALE - 1);

    state_t           r_state;
    logic [DW-1:0]    r_div;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_limit_q;
    logic             r_wrap;
    logic             r_done;

    logic w_div_last;
    logic w_at_limit;
    logic w_tick;

    assign w_div_last = (r_div == DIV_LAST);
    assign w_at_limit = (r_count == r_limit_q);
    assign w_tick     = (r_state == RUN) && w_div_last && !i_stop && !i_start && !i_pause;

    always_ff @(posedge i_clk or posedge i_rstn) begin
        if (i_rstn) begin
            r_state   <= IDLE;
            r_div     <= '0;
            r_count   <= '0;
            r_limit_q <= '0;
            r_wrap    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            r_done <= 1'b0;
            if (i_stop) begin
                r_state <= IDLE;
                r_count <= '0;
                r_div   <= '0;
            end else if (i_start) begin
                r_state <= RUN;
                // Start from PAUSE is a resume: count, phase and limit carry over.
                if (r_state != PAUSE) begin
                    r_count   <= '0;
                    r_div     <= '0;
                    r_limit_q <= i_limit;
                end
            end else if (i_pause) begin
                if (r_state == RUN)
                    r_state <= PAUSE;
            end else if (r_state == RUN) begin
                r_div <= w_div_last ? '0 : r_div + 1'b1;
                if (w_tick) begin
                    if (!w_at_limit) begin
                        r_count <= r_count + 1'b1;
                    end else if (!i_mode) begin
                        r_count <= '0;
                        r_wrap  <= 1'b1;
                    end else begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
            end
        end
    end

    assign o_count = r_count;
    assign o_state = r_state;
    assign o_busy  = (r_state == RUN) || (r_state == PAUSE);
    assign o_tick  = w_tick;
    assign o_wrap  = r_wrap;
    assign o_done  = r_done;

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: PRESCALE=4 and PRESCALE=1 instances share stimulus and are
// checked every cycle against a cycle-count reference model, plus literal scenario checks.
module tb_count_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, pause = 1'b0, stop = 1'b0, mode = 1'b0;
    logic [3:0] limit = 4'd0;

    logic [3:0] dc[2];
    logic [1:0] ds[2];
    logic       db[2], dt[2], dw[2], dd[2];

    int checks = 0;
    int errors = 0;

    localparam int PS[2] = '{4, 1};

    // model state: 0 idle, 1 run, 2 pause, 3 done; ph = RUN edges since last tick
    int m_st[2], m_cnt[2], m_ph[2], m_lim[2];
    bit m_wrap[2], m_done[2];

    count_sequencer #(.WIDTH(4), .PRESCALE(4)) u0 (
        .i_clk(clk), .i_rstn(rst), .i_start(start), .i_pause(pause), .i_stop(stop),
        .i_mode(mode), .i_limit(limit), .o_count(dc[0]), .o_busy(db[0]), .o_tick(dt[0]),
        .o_wrap(dw[0]), .o_done(dd[0]), .o_state(ds[0]));

    count_sequencer #(.WIDTH(4), .PRESCALE(1)) u1 (
        .i_clk(clk), .i_rstn(rst), .i_start(start), .i_pause(pause), .i_stop(stop),
        .i_mode(mode), .i_limit(limit), .o_count(dc[1]), .o_busy(db[1]), .o_tick(dt[1]),
        .o_wrap(dw[1]), .o_done(dd[1]), .o_state(ds[1]));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            int st, cnt, ph, lim;
            bit wr, dn;
            st = m_st[i]; cnt = m_cnt[i]; ph = m_ph[i]; lim = m_lim[i];
            wr = 1'b0; dn = 1'b0;
            if (rst) begin
                st = 0; cnt = 0; ph = 0; lim = 0;
            end else if (stop) begin
                st = 0; cnt = 0; ph = 0;
            end else if (start) begin
                if (st != 2) begin
                    cnt = 0; ph = 0; lim = int'(limit);
                end
                st = 1;
            end else if (pause) begin
                if (st == 1) st = 2;
            end else if (st == 1) begin
                ph = ph + 1;
                if (ph == PS[i]) begin
                    ph = 0;
                    if (cnt < lim) cnt = cnt + 1;
                    else if (!mode) begin cnt = 0; wr = 1'b1; end
                    else begin st = 3; dn = 1'b1; end
                end
            end
            m_st[i] <= st; m_cnt[i] <= cnt; m_ph[i] <= ph; m_lim[i] <= lim;
            m_wrap[i] <= wr; m_done[i] <= dn;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                bit etick;
                etick = (m_st[i] == 1) && (m_ph[i] == PS[i] - 1) && !stop && !start && !pause;
                chk($sformatf("u%0d.count", i), int'(dc[i]), m_cnt[i]);
                chk($sformatf("u%0d.state", i), int'(ds[i]), m_st[i]);
                chk($sformatf("u%0d.busy", i), int'(db[i]), int'(m_st[i] == 1 || m_st[i] == 2));
                chk($sformatf("u%0d.tick", i), int'(dt[i]), int'(etick));
                chk($sformatf("u%0d.wrap", i), int'(dw[i]), int'(m_wrap[i]));
                chk($sformatf("u%0d.done", i), int'(dd[i]), int'(m_done[i]));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic go(input int lim, input bit md);
        limit = 4'(lim); mode = md; start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic idle();
        stop = 1'b1;
        step(1);
        stop = 1'b0;
    endtask

    initial begin
        #11;
        chk("rst.count", int'(dc[0]), 0);
        chk("rst.state", int'(ds[0]), 0);
        chk("rst.busy", int'(db[0]), 0);
        rst = 1'b0;
        step(1);

        // mid-run reset at count 6
        go(10, 0); step(24);
        chk("t1.count6", int'(dc[0]), 6);
        rst = 1'b1; #1;
        chk("t1.count", int'(dc[0]), 0);
        chk("t1.state", int'(ds[0]), 0);
        chk("t1.busy", int'(db[0]), 0);
        chk("t1.wrapdone", int'(dw[0]) + int'(dd[0]), 0);
        rst = 1'b0;

        // free-run limit 3
        step(1); go(3, 0);
        step(1); chk("t2.u1c1", int'(dc[1]), 1);
        step(1); chk("t2.u1c2", int'(dc[1]), 2);
        step(2); chk("t2.u1c0", int'(dc[1]), 0); chk("t2.u1wrap", int'(dw[1]), 1);
        chk("t2.c4", int'(dc[0]), 1);
        step(4); chk("t2.c8", int'(dc[0]), 2);
        step(4); chk("t2.c12", int'(dc[0]), 3); chk("t2.w12", int'(dw[0]), 0);
        step(4); chk("t2.c16", int'(dc[0]), 0); chk("t2.w16", int'(dw[0]), 1);
        step(1); chk("t2.w17", int'(dw[0]), 0);
        step(3); chk("t2.c20", int'(dc[0]), 1);

        // one-shot limit 5
        idle(); go(5, 1);
        step(20); chk("t3.c20", int'(dc[0]), 5); chk("t3.s20", int'(ds[0]), 1);
        step(4); chk("t3.s24", int'(ds[0]), 3); chk("t3.done", int'(dd[0]), 1);
        chk("t3.busy", int'(db[0]), 0);
        step(1); chk("t3.done25", int'(dd[0]), 0); chk("t3.c25", int'(dc[0]), 5);

        // pause at count 2, div 1, then resume
        idle(); go(9, 0); step(9);
        chk("t4.c9", int'(dc[0]), 2);
        pause = 1'b1; step(10); pause = 1'b0;
        chk("t4.frozen", int'(dc[0]), 2); chk("t4.paused", int'(ds[0]), 2);
        start = 1'b1; step(1); start = 1'b0;
        step(2); chk("t4.r2", int'(dc[0]), 2);
        step(1); chk("t4.r3", int'(dc[0]), 3); chk("t4.run", int'(ds[0]), 1);

        // priorities
        idle(); go(12, 0); step(5);
        stop = 1'b1; start = 1'b1; step(1); stop = 1'b0; start = 1'b0;
        chk("t5.stopwin", int'(ds[0]), 0); chk("t5.stopcnt", int'(dc[0]), 0);
        go(12, 0); step(28); chk("t5.c7", int'(dc[0]), 7);
        go(3, 0); chk("t5.restart", int'(dc[0]), 0);
        limit = 4'd15;
        step(12); chk("t5.c3", int'(dc[0]), 3);
        step(4); chk("t5.reload", int'(dc[0]), 0); chk("t5.wrap", int'(dw[0]), 1);
        idle(); go(12, 0); step(3);
        pause = 1'b1; step(1); pause = 1'b0;
        chk("t5.pausetick", int'(ds[0]), 2); chk("t5.pausecnt", int'(dc[0]), 0);

        // boundaries
        idle(); go(15, 0); step(60);
        chk("t6.c15", int'(dc[0]), 15);
        step(4); chk("t6.c0", int'(dc[0]), 0); chk("t6.wrap", int'(dw[0]), 1);
        idle(); go(0, 1); step(3);
        chk("t6.run3", int'(ds[0]), 1);
        step(1); chk("t6.done", int'(ds[0]), 3); chk("t6.cnt0", int'(dc[0]), 0);
        chk("t6.dpulse", int'(dd[0]), 1);

        // randomized run-control traffic
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 199));
            stop  = (r < 3);
            start = (r >= 3 && r < 11);
            pause = (r >= 11 && r < 19);
            limit = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) mode = ~mode;
            if (r == 199 && $urandom_range(0, 3) == 0) begin
                rst = 1'b1; #1; rst = 1'b0;
            end
            step(1);
        end
        start = 1'b0; pause = 1'b0; stop = 1'b0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
